dsm_dac_mod2: RTL



---
 rtl/dsm_dac_mod2.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/dsm_dac_mod2.sv
// dsm_dac_mod2: 1st/2nd-order CIFB single-bit delta-sigma DAC, saturating
// integrators, one-deep sample buffer. Optional dither: DSM_DAC_DITHER_EN.
module dsm_dac_mod2 #(
   parameter int DATA_WIDTH = 16,
   parameter int ACC_WIDTH  = DATA_WIDTH + 4,
   parameter int ORDER      = 2,
   parameter int OSR        = 64
) (
   input  logic                         i_clk,
   input  logic                         i_rst_n,
   input  logic                         i_en,
   input  logic signed [DATA_WIDTH-1:0] i_data,
   input  logic                         i_valid,
   output logic                         o_ready,
   input  logic                         i_clr_flags,
   output logic                         o_dac_bitstream,
   output logic                         o_overload,
   output logic                         o_underrun
);

   localparam int CW = $clog2(OSR);
   // Two guard bits so i2 + i1' - v cannot wrap before the clamp.
   localparam int SW = ACC_WIDTH + 2;
   localparam logic [CW-1:0] CNT_LAST = CW'(OSR - 1);

   typedef logic signed [SW-1:0] wide_t;

   localparam wide_t FB =
      wide_t'({{(SW-DATA_WIDTH){1'b0}}, 1'b1, {(DATA_WIDTH-1){1'b0}}});
   localparam wide_t SAT_MAX =
      wide_t'({{(SW-ACC_WIDTH+1){1'b0}}, {(ACC_WIDTH-1){1'b1}}});
   localparam wide_t SAT_MIN =
      wide_t'({{(SW-ACC_WIDTH+1){1'b1}}, {(ACC_WIDTH-1){1'b0}}});

   if (ORDER != 1 && ORDER != 2) begin : g_bad_order
      $error("dsm_dac_mod2: ORDER must be 1 or 2");
   end
   if (ACC_WIDTH < DATA_WIDTH + 3) begin : g_bad_acc
      $error("dsm_dac_mod2: ACC_WIDTH must be >= DATA_WIDTH+3");
   end
   if (OSR < 2) begin : g_bad_osr
      $error("dsm_dac_mod2: OSR must be >= 2");
   end

   function automatic wide_t ext(input logic signed [ACC_WIDTH-1:0] a);
      return wide_t'({{(SW-ACC_WIDTH){a[ACC_WIDTH-1]}}, a});
   endfunction

   function automatic logic clips(input wide_t s);
      return (s > SAT_MAX) || (s < SAT_MIN);
   endfunction

   function automatic logic signed [ACC_WIDTH-1:0] sat(input wide_t s);
      if (s > SAT_MAX) begin
         return {1'b0, {(ACC_WIDTH-1){1'b1}}};
      end else if (s < SAT_MIN) begin
         return {1'b1, {(ACC_WIDTH-1){1'b0}}};
      end else begin
         return s[ACC_WIDTH-1:0];
      end
   endfunction

   logic signed [DATA_WIDTH-1:0] pending_q, pending_d;
   logic signed [DATA_WIDTH-1:0] sample_q, sample_d;
   logic                         pend_vld_q, pend_vld_d;
   logic [CW-1:0]                cnt_q, cnt_d;
   logic signed [ACC_WIDTH-1:0]  i1_q, i1_d, q_acc;
   logic                         bit_q, bit_d;
   logic                         ovl_q, ovl_d;
   logic                         und_q, und_d;
   logic                         tick, wrap, load;
   logic                         clip1, clip2;
   wide_t                        x, v, s1, qsum, dith;

`ifdef DSM_DAC_DITHER_EN
   logic [15:0] lfsr_q, lfsr_d;

   // Galois form of x^16+x^14+x^13+x^11+1; dither spans -8..+7.
   always_comb begin
      lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
      dith   = wide_t'($signed({1'b0, lfsr_q[3:0]})) - wide_t'(8);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         lfsr_q <= 16'hACE1;
      end else if (i_en) begin
         lfsr_q <= lfsr_d;
      end
   end
`else
   always_comb dith = '0;
`endif

   always_comb begin
      tick       = i_en;
      wrap       = tick && (cnt_q == CNT_LAST);
      load       = wrap && pend_vld_q;
      o_ready    = !pend_vld_q;
      pending_d  = pending_q;
      pend_vld_d = pend_vld_q;
      if (i_valid && !pend_vld_q) begin
         pending_d  = i_data;
         pend_vld_d = 1'b1;
      end else if (load) begin
         pend_vld_d = 1'b0;
      end
      sample_d = load ? pending_q : sample_q;
      cnt_d    = wrap ? '0 : cnt_q + CW'(1);
      x = wide_t'({{(SW-DATA_WIDTH){sample_q[DATA_WIDTH-1]}}, sample_q});
      v     = bit_q ? FB : -FB;
      s1    = ext(i1_q) + x - v;
      clip1 = clips(s1);
      i1_d  = sat(s1);
   end

   if (ORDER == 2) begin : g_ord2
      logic signed [ACC_WIDTH-1:0] i2_q, i2_d;
      wide_t                       s2;

      always_comb begin
         s2    = ext(i2_q) + ext(i1_d) - v;
         clip2 = clips(s2);
         i2_d  = sat(s2);
         q_acc = i2_d;
      end

      always_ff @(posedge i_clk or negedge i_rst_n) begin
         if (!i_rst_n) begin
            i2_q <= '0;
         end else if (i_en) begin
            i2_q <= i2_d;
         end
      end
   end else begin : g_ord1
      always_comb begin
         clip2 = 1'b0;
         q_acc = i1_d;
      end
   end

   // Dither only enters the compare; integrators never see it.
   always_comb begin
      qsum  = ext(q_acc) + dith;
      bit_d = !qsum[SW-1];
      ovl_d = (tick && (clip1 || clip2)) || (ovl_q && !i_clr_flags);
      und_d = (wrap && !pend_vld_q) || (und_q && !i_clr_flags);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         pending_q  <= '0;
         pend_vld_q <= 1'b0;
         sample_q   <= '0;
         cnt_q      <= '0;
         i1_q       <= '0;
         bit_q      <= 1'b0;
         ovl_q      <= 1'b0;
         und_q      <= 1'b0;
      end else begin
         pending_q  <= pending_d;
         pend_vld_q <= pend_vld_d;
         ovl_q      <= ovl_d;
         und_q      <= und_d;
         if (i_en) begin
            cnt_q    <= cnt_d;
            sample_q <= sample_d;
            i1_q     <= i1_d;
            bit_q    <= bit_d;
         end
      end
   end

   assign o_dac_bitstream = bit_q;
   assign o_overload      = ovl_q;
   assign o_underrun      = und_q;

endmodule
